accel_out_buffer: RTL and testbench

- Downstream stage of the accelerator block: captures its 128-bit result words (valid_fifoout / data_out / last_out) into a small FWFT FIFO and presents them on a ready/valid master interface toward the output data FIFO / DMA writer.
- Generates the accelerator's `full` backpressure early, so that the accelerator's 3-cycle pipeline tail always fits.
- Tracks frame boundaries, counts words per frame, and flags overflow.

---
 rtl/accel_pkg.sv | 22 ++
 rtl/accel_out_fifo.sv | 44 ++++
 rtl/accel_out_buffer.sv | 136 +++++++++++++
 tb/tb_accel_out_buffer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared accelerator widths, output-stage FSM encodings and byte-swap helper
package accel_pkg;

  localparam int DATA_W = 128;

  typedef enum logic [3:0] {
    OB_IDLE   = 4'b0001,
    OB_STREAM = 4'b0010,
    OB_DRAIN  = 4'b0100,
    OB_DONE   = 4'b1000
  } ob_state_t;

  // Byte 0 <-> byte 15 reversal for the host little-endian layout
  function automatic logic [DATA_W-1:0] byte_swap128(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 8; i++) begin
      r[8*i +: 8] = d[DATA_W - 8 - 8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/accel_out_fifo.sv
// rtl/accel_out_fifo.sv - generic first-word-fall-through FIFO with occupancy output
module accel_out_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 129,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage array; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/accel_out_buffer.sv
// rtl/accel_out_buffer.sv - accelerator result buffer with early backpressure and frame tracking (option: OUT_BYTE_SWAP_EN)
module accel_out_buffer
  import accel_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int SLACK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              last_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              full_out,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic [31:0]       word_count,
  output logic              frame_done,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] FULL_TH = (AW+1)'(DEPTH - SLACK);

  ob_state_t         state;
  ob_state_t         state_next;
  logic [AW:0]       occ;
  logic [AW:0]       occ_next;
  logic [AW:0]       last_cnt;
  logic [DATA_W:0]   head;
  logic [DATA_W-1:0] head_data;
  logic              head_last;
  logic              pop;
  logic              pop_last;
  logic              wr_acc;
  logic              drop;
  logic              new_frame;

  accel_out_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_acc),
    .wr_data ({last_in, data_in}),
    .rd_en   (pop),
    .rd_data (head),
    .count   (occ)
  );

  assign head_data = head[DATA_W-1:0];
  assign head_last = head[DATA_W];
  assign m_valid   = (occ != '0);
  assign m_last    = m_valid & head_last;
  assign pop       = m_valid & m_ready;
  assign pop_last  = pop & head_last;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign wr_acc    = valid_in & ((occ != DEPTH_C) | pop);
  assign drop      = valid_in & ~wr_acc;

`ifdef OUT_BYTE_SWAP_EN
  assign m_data = byte_swap128(head_data);
`else
  assign m_data = head_data;
`endif

  // Occupancy after this edge, used for the registered early-full flag
  always_comb begin
    occ_next = occ;
    if (wr_acc && !pop)      occ_next = occ + (AW+1)'(1);
    else if (!wr_acc && pop) occ_next = occ - (AW+1)'(1);
  end

  // Frame bookkeeping: count of last-marked entries held, word counter, overflow, full
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_cnt   <= '0;
      new_frame  <= 1'b1;
      word_count <= '0;
      overflow   <= 1'b0;
      full_out   <= 1'b0;
    end else begin
      case ({wr_acc & last_in, pop_last})
        2'b10:   last_cnt <= last_cnt + (AW+1)'(1);
        2'b01:   last_cnt <= last_cnt - (AW+1)'(1);
        default: last_cnt <= last_cnt;
      endcase
      // The word after a last-marked write opens a new frame wherever the FSM is
      if (wr_acc) begin
        new_frame  <= last_in;
        word_count <= new_frame ? 32'd1 : word_count + 32'd1;
      end
      if (drop) overflow <= 1'b1;
      full_out <= (occ_next >= FULL_TH);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) state <= OB_IDLE;
    else        state <= state_next;
  end

  // FSM next state; a last-marked pop always ends a frame so no pulse is lost
  always_comb begin
    state_next = state;
    case (state)
      OB_IDLE: begin
        if (wr_acc) state_next = last_in ? OB_DRAIN : OB_STREAM;
      end
      OB_STREAM: begin
        if (pop_last)                                  state_next = OB_DONE;
        else if ((wr_acc && last_in) || last_cnt != '0) state_next = OB_DRAIN;
      end
      OB_DRAIN: begin
        if (pop_last) state_next = OB_DONE;
      end
      OB_DONE: begin
        if (pop_last)              state_next = OB_DONE;
        else if (occ_next != '0)   state_next = OB_STREAM;
        else                       state_next = OB_IDLE;
      end
      default: state_next = OB_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    frame_done = 1'b0;
    if (state == OB_DONE) frame_done = 1'b1;
  end

endmodule

// File: tb/tb_accel_out_buffer.sv
// tb/tb_accel_out_buffer.sv - self-checking bench for accel_out_buffer against a queue reference model
module tb_accel_out_buffer;
  import accel_pkg::*;

  localparam int DEPTH = 16;
  localparam int SLACK = 4;

  typedef struct {
    logic         last;
    logic [127:0] data;
  } ent_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_in;
  logic         last_in;
  logic [127:0] data_in;
  logic         full_out;
  logic [127:0] m_data;
  logic         m_valid;
  logic         m_last;
  logic         m_ready;
  logic [31:0]  word_count;
  logic         frame_done;
  logic         overflow;

  ent_t         q[$];
  logic         mdl_ovf;
  logic [31:0]  mdl_wc;
  logic         mdl_newf;
  logic         mdl_fd;
  int           checks = 0;
  int           errors = 0;
  int           fd_seen = 0;

  always #5 clk = ~clk;

  accel_out_buffer #(.DEPTH(DEPTH), .SLACK(SLACK)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .last_in    (last_in),
    .data_in    (data_in),
    .full_out   (full_out),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .word_count (word_count),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] host_order(input logic [127:0] d);
    logic [127:0] r;
`ifdef OUT_BYTE_SWAP_EN
    for (int b = 0; b < 16; b++) r[127 - 8*b -: 8] = d[8*b +: 8];
`else
    r = d;
`endif
    return r;
  endfunction

  task automatic check_all();
    chk("m_valid", m_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("m_data", m_data, host_order(q[0].data));
      chk("m_last", m_last, q[0].last);
    end else begin
      chk("m_last_empty", m_last, 1'b0);
    end
    chk("full_out", full_out, q.size() >= DEPTH - SLACK);
    chk("overflow", overflow, mdl_ovf);
    chk("word_count", word_count, mdl_wc);
    chk("frame_done", frame_done, mdl_fd);
    chk("occupancy", dut.occ, q.size());
    if (frame_done === 1'b1) fd_seen++;
  endtask

  task automatic step(input logic v, input logic l, input logic [127:0] d, input logic r);
    bit pop;
    bit acc;
    valid_in = v;
    last_in  = l;
    data_in  = d;
    m_ready  = r;
    pop = r && (q.size() > 0);
    acc = v && ((q.size() < DEPTH) || pop);
    @(posedge clk);
    mdl_fd = pop && q[0].last;
    if (pop) void'(q.pop_front());
    if (acc) begin
      q.push_back('{last: l, data: d});
      mdl_wc   = mdl_newf ? 32'd1 : mdl_wc + 32'd1;
      mdl_newf = l;
    end else if (v) begin
      mdl_ovf = 1'b1;
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    valid_in = 1'($urandom);
    last_in  = 1'($urandom);
    m_ready  = 1'($urandom);
    @(posedge clk);
    q.delete();
    mdl_ovf  = 1'b0;
    mdl_wc   = '0;
    mdl_newf = 1'b1;
    mdl_fd   = 1'b0;
    #1;
    reset    = 1'b1;
    valid_in = 1'b0;
    last_in  = 1'b0;
    m_ready  = 1'b0;
    check_all();
    chk("state_idle_after_reset", dut.state, OB_IDLE);
  endtask

  initial begin
    logic [127:0] rd;
    reset    = 1'b0;
    valid_in = 1'b0;
    last_in  = 1'b0;
    data_in  = '0;
    m_ready  = 1'b0;
    @(posedge clk);
    do_reset();

    // Single 5-word frame, consumer always ready
    for (int k = 1; k <= 5; k++) step(1'b1, k == 5, 128'(k), 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("frame_done_after_last_pop", frame_done, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("wc_frame5", word_count, 32'd5);
    chk("state_idle_frame5", dut.state, OB_IDLE);

    // Fill with consumer stalled: early full at 12, overflow on the 17th write
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 128'(100 + i), 1'b0);
    chk("full_at_12", full_out, 1'b1);
    for (int i = 12; i < 16; i++) step(1'b1, 1'b0, 128'(100 + i), 1'b0);
    chk("no_overflow_at_16", overflow, 1'b0);
    step(1'b1, 1'b0, 128'hdead, 1'b0);
    chk("overflow_on_17th", overflow, 1'b1);

    // Full FIFO with simultaneous pop and push
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 128'(200 + i), 1'b0);
    step(1'b1, 1'b0, 128'h5a5a, 1'b1);
    chk("occ_full_rw", dut.occ, 5'd16);
    chk("no_overflow_full_rw", overflow, 1'b0);

    // Back-to-back frames A (3 words) and B (2 words), released afterwards
    do_reset();
    fd_seen = 0;
    for (int i = 0; i < 3; i++) step(1'b1, i == 2, 128'(16'hA0 + i), 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, i == 1, 128'(16'hB0 + i), 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1);
    chk("two_frame_done_pulses", 128'(fd_seen), 128'd2);
    chk("wc_frame_b", word_count, 32'd2);

    // Reset mid-frame with 7 words held, then a normal frame
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 128'(300 + i), 1'b0);
    chk("occ_7_before_reset", dut.occ, 5'd7);
    do_reset();
    for (int k = 1; k <= 3; k++) step(1'b1, k == 3, 128'(400 + k), 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("frame_done_after_reset", frame_done, 1'b1);
    chk("wc_after_reset", word_count, 32'd3);

`ifdef OUT_BYTE_SWAP_EN
    do_reset();
    step(1'b1, 1'b1, 128'h000102030405060708090a0b0c0d0e0f, 1'b0);
    chk("byte_swap", m_data, 128'h0f0e0d0c0b0a09080706050403020100);
`endif

    // Randomized traffic alternating between mostly-stalled and mostly-ready phases
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        rd = {$urandom, $urandom, $urandom, $urandom};
        step($urandom_range(0, 99) < 70,
             $urandom_range(0, 4) == 0,
             rd,
             $urandom_range(0, 99) < (((i / 100) % 2 == 1) ? 20 : 85));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
